// File: rtl/aes_pkg.sv
// Shared AES constants, sequencer state type and byte-slice helper.
// Byte 0 of the state lives in the most significant bits.
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_BYTES   = 16;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } aes_seq_state_e;

   function automatic int byte_msb(input int n);
      return AES_STATE_W - 1 - 8 * n;
   endfunction

endpackage

// File: rtl/aes_inv_sbox_bank.sv
// Combinational bank of NUM_SBOX inverse S-boxes on a packed byte bus.
// Bus byte 0 is the most significant byte, matching the state order.
module aes_inv_sbox_bank #(
   parameter int NUM_SBOX = 4
) (
   input  logic [NUM_SBOX*8-1:0] din_i,
   output logic [NUM_SBOX*8-1:0] dout_o
);

   for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
      aes_sub_inv_sbox u_sbox (
         .din_i  (din_i[NUM_SBOX*8-1-8*k -: 8]),
         .dout_o (dout_o[NUM_SBOX*8-1-8*k -: 8])
      );
   end

endmodule

// File: rtl/aes_sub_inv_sbox.sv
// AES inverse S-box: inverse affine map followed by GF(2^8) inversion.
// The inverse is x^254, so zero maps to zero without a special case.
module aes_sub_inv_sbox (
   input  logic [7:0] din_i,
   output logic [7:0] dout_o
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   logic [7:0] aff;
   logic [7:0] x2, x4, x8, x16, x32, x64, x128;

   assign aff = {din_i[6:0], din_i[7]}
              ^ {din_i[4:0], din_i[7:5]}
              ^ {din_i[1:0], din_i[7:2]}
              ^ 8'h05;

   assign x2   = gmul(aff, aff);
   assign x4   = gmul(x2, x2);
   assign x8   = gmul(x4, x4);
   assign x16  = gmul(x8, x8);
   assign x32  = gmul(x16, x16);
   assign x64  = gmul(x32, x32);
   assign x128 = gmul(x64, x64);

   assign dout_o = gmul(gmul(gmul(x2, x4), gmul(x8, x16)),
                        gmul(gmul(x32, x64), x128));

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Inverse SubBytes sequencer: substitutes the 128-bit state in place,
// one group of NUM_SBOX bytes per cycle, behind valid/ready handshakes.
module aes_inv_sub_bytes_seq
   import aes_pkg::*;
#(
   parameter int NUM_SBOX = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_state,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_state,
   output logic                   busy
);

   localparam int NUM_GRP = AES_BYTES / NUM_SBOX;
   localparam int CNT_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
   localparam int GRP_W   = NUM_SBOX * 8;
   localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GRP - 1);

   if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
       NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
      $error("NUM_SBOX must be 1, 2, 4, 8 or 16");
   end

   aes_seq_state_e         state_q, state_d;
   logic [CNT_W-1:0]       grp_cnt_q, grp_cnt_d;
   logic [AES_STATE_W-1:0] state_reg_q, state_reg_d;
   logic [GRP_W-1:0]       grp_in, grp_out;

   always_comb begin
      grp_in = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         if (grp_cnt_q == CNT_W'(g))
            grp_in = state_reg_q[byte_msb(g * NUM_SBOX) -: GRP_W];
      end
   end

   aes_inv_sbox_bank #(
      .NUM_SBOX (NUM_SBOX)
   ) u_bank (
      .din_i  (grp_in),
      .dout_o (grp_out)
   );

   always_comb begin
      state_d     = state_q;
      grp_cnt_d   = grp_cnt_q;
      state_reg_d = state_reg_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_reg_d = in_state;
               grp_cnt_d   = '0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            for (int g = 0; g < NUM_GRP; g++) begin
               if (grp_cnt_q == CNT_W'(g))
                  state_reg_d[byte_msb(g * NUM_SBOX) -: GRP_W] = grp_out;
            end
            if (grp_cnt_q == LAST_GRP) begin
               grp_cnt_d = '0;
               state_d   = DONE;
            end else begin
               grp_cnt_d = grp_cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grp_cnt_q   <= '0;
         state_reg_q <= '0;
      end else begin
         state_q     <= state_d;
         grp_cnt_q   <= grp_cnt_d;
         state_reg_q <= state_reg_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_state = state_reg_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Bench for the inverse SubBytes sequencer: vector table, handshake
// corner cases and a randomized scoreboard against a table model.
module tb_aes_inv_sub_bytes_seq;

   localparam int NDUT = 5;
   localparam int MAIN = 2;

   typedef struct {
      logic [127:0] din;
      logic [127:0] dexp;
      string        name;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_state = '0;
   logic         in_ready [NDUT];
   logic         out_valid[NDUT];
   logic         busy     [NDUT];
   logic [127:0] out_state[NDUT];

   int         checks = 0;
   int         errors = 0;
   logic [7:0] inv_tbl[256];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      aes_inv_sub_bytes_seq #(
         .NUM_SBOX (1 << g)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready[g]),
         .in_state  (in_state),
         .out_valid (out_valid[g]),
         .out_ready (out_ready),
         .out_state (out_state[g]),
         .busy      (busy[g])
      );
   end

   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h11b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
      logic [15:0] t;
      t = {v, v} << k;
      return t[15:8];
   endfunction

   task automatic build_model();
      logic [7:0] y, s;
      for (int x = 0; x < 256; x++) begin
         y = '0;
         for (int c = 1; c < 256; c++)
            if (gf_mul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
         s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
         inv_tbl[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] ref_state(input logic [127:0] s);
      logic [127:0] r;
      for (int b = 0; b < 16; b++)
         r[127-8*b -: 8] = inv_tbl[s[127-8*b -: 8]];
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!in_ready[MAIN] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[MAIN]) chk("idle_timeout", 0, 1);
   endtask

   task automatic one_txn(input vec_t v);
      int n = 0;
      out_ready = 1'b1;
      wait_idle();
      in_valid = 1'b1;
      in_state = v.din;
      while (n < 40) begin
         @(negedge clk);
         n++;
         in_valid = 1'b0;
         if (out_valid[MAIN]) break;
      end
      chk({v.name, "_latency"}, n, 5);
      chk({v.name, "_data"}, out_state[MAIN], v.dexp);
      @(negedge clk);
      chk({v.name, "_one_cycle"}, out_valid[MAIN], 0);
   endtask

   task automatic lat_all(input logic [127:0] din, input logic [127:0] dexp);
      int lat[NDUT];
      out_ready = 1'b1;
      for (int g = 0; g < NDUT; g++) lat[g] = -1;
      in_valid = 1'b1;
      in_state = din;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         in_valid = 1'b0;
         for (int g = 0; g < NDUT; g++)
            if (lat[g] < 0 && out_valid[g]) begin
               lat[g] = n;
               chk($sformatf("lat_data_ns%0d", 1 << g), out_state[g], dexp);
            end
      end
      for (int g = 0; g < NDUT; g++)
         chk($sformatf("lat_ns%0d", 1 << g), lat[g], 16 / (1 << g) + 1);
   endtask

   vec_t         vecs[5];
   vec_t         b2b[3];
   logic [127:0] held;
   logic [127:0] exp_q[$];
   int           acc, got, last, sent, rcv, n;
   bit           seen;

   initial begin
      build_model();
      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                  128'h52096ad53036a538bf40a39e81f3d7fb, "v_count"};
      vecs[1] = '{{16{8'h63}}, '0, "v_63"};
      vecs[2] = '{'0, {16{8'h52}}, "v_00"};
      vecs[3] = '{{16{8'h10}}, {16{8'h7c}}, "v_10"};
      vecs[4] = '{{16{8'hff}}, {16{8'h7d}}, "v_ff"};

      do_reset();
      chk("rst_in_ready", in_ready[MAIN], 1);
      chk("rst_out_valid", out_valid[MAIN], 0);
      chk("rst_busy", busy[MAIN], 0);
      chk("rst_out_state", out_state[MAIN], 0);

      for (int i = 0; i < 5; i++) one_txn(vecs[i]);

      do_reset();
      lat_all({16{8'h63}}, '0);
      lat_all('0, {16{8'h52}});

      out_ready = 1'b0;
      wait_idle();
      in_valid = 1'b1;
      in_state = vecs[0].din;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid[MAIN] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("bp_reach_done", out_valid[MAIN], 1);
      held = out_state[MAIN];
      chk("bp_data", held, vecs[0].dexp);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_state = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         if (!out_valid[MAIN] || out_state[MAIN] !== held ||
             in_ready[MAIN] || !busy[MAIN]) seen = 1'b1;
      end
      chk("bp_stable", seen, 0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", out_valid[MAIN], 0);
      chk("bp_release_ready", in_ready[MAIN], 1);
      in_valid = 1'b0;

      in_valid = 1'b1;
      in_state = vecs[4].din;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_in_ready", in_ready[MAIN], 1);
      chk("mid_rst_out_valid", out_valid[MAIN], 0);
      chk("mid_rst_busy", busy[MAIN], 0);
      chk("mid_rst_out_state", out_state[MAIN], 0);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid[MAIN]) seen = 1'b1;
      end
      chk("mid_rst_no_pulse", seen, 0);

      rst = 1'b1;
      in_valid = 1'b1;
      in_state = vecs[3].din;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      chk("rst_vs_valid_busy", busy[MAIN], 0);
      chk("rst_vs_valid_state", out_state[MAIN], 0);

      b2b[0] = vecs[0];
      b2b[1] = '{128'h101112131415161718191a1b1c1d1e1f,
                 ref_state(128'h101112131415161718191a1b1c1d1e1f), "b2b_1"};
      b2b[2] = vecs[4];
      acc = 0; got = 0; last = -1;
      out_ready = 1'b1;
      for (int c = 0; c < 100 && got < 3; c++) begin
         @(negedge clk);
         if (out_valid[MAIN]) begin
            chk($sformatf("b2b_data%0d", got), out_state[MAIN], b2b[got].dexp);
            if (last >= 0) chk("b2b_period", c - last, 6);
            last = c;
            got++;
         end
         in_valid = (acc < 3);
         in_state = b2b[(acc < 3) ? acc : 0].din;
         if (in_valid && in_ready[MAIN]) acc++;
      end
      in_valid = 1'b0;
      chk("b2b_results", got, 3);
      chk("b2b_accepts", acc, 3);

      do_reset();
      sent = 0; rcv = 0;
      for (int c = 0; c < 40000 && rcv < 1000; c++) begin
         @(negedge clk);
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_state  = {$urandom, $urandom, $urandom, $urandom};
         out_ready = ($urandom_range(0, 2) != 0);
         if (out_valid[MAIN] && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("rnd_unexpected_output", 1, 0);
            end else begin
               chk("rnd_data", out_state[MAIN], exp_q.pop_front());
            end
            rcv++;
         end
         if (in_valid && in_ready[MAIN]) begin
            exp_q.push_back(ref_state(in_state));
            sent++;
         end
      end
      in_valid = 1'b0;
      chk("rnd_sent", sent, 1000);
      chk("rnd_received", rcv, sent);
      chk("rnd_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
